// File: rtl/otf_pkg.sv
// Shared digit encodings, FSM state type and digit decoder for the
// online-to-conventional converter.
package otf_pkg;

    localparam logic [1:0] DIGIT_POS = 2'b10;
    localparam logic [1:0] DIGIT_NEG = 2'b01;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    typedef struct packed {
        logic pos;
        logic zero;
        logic neg;
    } digit_dec_t;

    // Both 2'b00 and 2'b11 encode zero.
    function automatic digit_dec_t decode_digit(input logic [1:0] d);
        digit_dec_t r;
        r.pos  = (d == DIGIT_POS);
        r.neg  = (d == DIGIT_NEG);
        r.zero = !(r.pos || r.neg);
        return r;
    endfunction

endpackage

// File: rtl/otf_append.sv
// On-the-fly conversion step: appends one signed digit to Q and QM (QM = Q - 1 ulp).
// Only the low N bits of Q/QM feed the result; the old sign bit shifts out.
module otf_append
    import otf_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] q_low,
    input  logic [N-1:0] qm_low,
    input  logic [1:0]   digit,
    output logic [N:0]   q_next_c,
    output logic [N:0]   qm_next_c
);

    digit_dec_t dec;

    always_comb begin
        dec       = decode_digit(digit);
        q_next_c  = {q_low, 1'b0};
        qm_next_c = {qm_low, 1'b1};
        case ({dec.pos, dec.zero, dec.neg})
            3'b100: begin
                q_next_c  = {q_low, 1'b1};
                qm_next_c = {q_low, 1'b0};
            end
            3'b001: begin
                q_next_c  = {qm_low, 1'b1};
                qm_next_c = {qm_low, 1'b0};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/otf_to_binary.sv
// Serial MSD-first signed-digit to two's-complement converter (N digits -> N+1 bits).
// Optional res_zero output enabled by defining OTF_ZERO_FLAG_EN.
module otf_to_binary
    import otf_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   x,
    input  logic         In_vld,
    output logic         In_rdy,
    output logic [N:0]   res,
    output logic         Out_vld,
    input  logic         Out_rdy
`ifdef OTF_ZERO_FLAG_EN
    ,
    output logic         res_zero
`endif
);

    localparam int unsigned W  = N + 1;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    state_t         state;
    logic [W-1:0]   q;
    logic [W-1:0]   qm;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   q_next_c;
    logic [W-1:0]   qm_next_c;
    logic           accept_c;
    logic           out_hs_c;
    logic           last_c;

    assign accept_c = In_vld && In_rdy;
    assign out_hs_c = Out_vld && Out_rdy;
    assign last_c   = (cnt == CW'(N - 1));

    otf_append #(.N(N)) u_append (
        .q_low     (q[N-1:0]),
        .qm_low    (qm[N-1:0]),
        .digit     (x),
        .q_next_c  (q_next_c),
        .qm_next_c (qm_next_c)
    );

    // Word assembly, digit counter and both handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ACCUM;
            q       <= '0;
            qm      <= '1;
            cnt     <= '0;
            res     <= '0;
            Out_vld <= 1'b0;
            In_rdy  <= 1'b1;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept_c) begin
                        q  <= q_next_c;
                        qm <= qm_next_c;
                        if (last_c) begin
                            res     <= q_next_c;
                            Out_vld <= 1'b1;
                            In_rdy  <= 1'b0;
                            state   <= DONE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_hs_c) begin
                        Out_vld <= 1'b0;
                        In_rdy  <= 1'b1;
                        q       <= '0;
                        qm      <= '1;
                        cnt     <= '0;
                        state   <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

`ifdef OTF_ZERO_FLAG_EN
    // A zero result is non-redundant only when every digit of the word is zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_zero <= 1'b1;
        end else if (out_hs_c) begin
            res_zero <= 1'b1;
        end else if (accept_c) begin
            res_zero <= res_zero && decode_digit(x).zero;
        end
    end
`endif

    a_qm_tracks_q: assert property (@(posedge clk) disable iff (!rst_n)
        (q - qm) == W'(1));

    a_rdy_vld_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        In_rdy != Out_vld);

    a_hold_when_stalled: assert property (@(posedge clk) disable iff (!rst_n)
        (Out_vld && !Out_rdy) |=> (Out_vld && $stable(res)));

endmodule

// File: tb/tb_otf_to_binary.sv
// Directed bench for otf_to_binary (N = 4) with an arithmetic reference model.
module tb_otf_to_binary;

    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   x = 2'b00;
    logic         In_vld = 1'b0;
    logic         In_rdy;
    logic [N:0]   res;
    logic         Out_vld;
    logic         Out_rdy = 1'b1;
`ifdef OTF_ZERO_FLAG_EN
    logic         res_zero;
`endif

    int checks = 0;
    int failures = 0;

    otf_to_binary #(.N(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .x       (x),
        .In_vld  (In_vld),
        .In_rdy  (In_rdy),
        .res     (res),
        .Out_vld (Out_vld),
        .Out_rdy (Out_rdy)
`ifdef OTF_ZERO_FLAG_EN
        ,
        .res_zero(res_zero)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dval(input logic [1:0] d);
        return int'(d[1]) - int'(d[0]);
    endfunction

    // Reference model: value accumulates as a plain integer, v = 2v + d.
    int         m_val = 0;
    int         m_cnt = 0;
    bit         m_done = 1'b0;
    logic [N:0] m_res = '0;
    bit         m_allzero = 1'b1;
    bit         m_zero = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_val = 0; m_cnt = 0; m_done = 1'b0; m_res = '0;
            m_allzero = 1'b1; m_zero = 1'b1;
        end else if (m_done) begin
            if (Out_rdy) begin
                m_done = 1'b0; m_val = 0; m_cnt = 0; m_allzero = 1'b1;
            end
        end else if (In_vld) begin
            m_val     = m_val * 2 + dval(x);
            m_allzero = m_allzero && (dval(x) == 0);
            m_cnt++;
            if (m_cnt == N) begin
                m_res  = (N+1)'(m_val);
                m_zero = m_allzero;
                m_done = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        check("mdl_in_rdy", 32'(In_rdy), 32'(!m_done));
        check("mdl_out_vld", 32'(Out_vld), 32'(m_done));
        check("mdl_res", 32'(res), 32'(m_res));
`ifdef OTF_ZERO_FLAG_EN
        if (m_done) check("mdl_res_zero", 32'(res_zero), 32'(m_zero));
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_digit(input logic [1:0] d);
        int t = 0;
        x = d;
        In_vld = 1'b1;
        while (!In_rdy && t < 50) begin
            step();
            t++;
        end
        if (!In_rdy) check("accept_timeout", 32'(In_rdy), 32'd1);
        step();
    endtask

    // First digit in w[7:6].
    task automatic send_word(input logic [7:0] w, input bit toggle);
        for (int i = 0; i < 4; i++) begin
            send_digit(w[7-2*i -: 2]);
            if (toggle && i < 3) begin
                In_vld = 1'b0;
                step();
            end
        end
        In_vld = 1'b0;
    endtask

    task automatic finish_word(input string name, input logic [N:0] exp);
        check({name, "_res"}, 32'(res), 32'(exp));
        check({name, "_vld"}, 32'(Out_vld), 32'd1);
        check({name, "_rdy"}, 32'(In_rdy), 32'd0);
        step();
        check({name, "_vld_drop"}, 32'(Out_vld), 32'd0);
        check({name, "_rdy_back"}, 32'(In_rdy), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) step();
        check("rst_in_rdy", 32'(In_rdy), 32'd1);
        check("rst_out_vld", 32'(Out_vld), 32'd0);
        check("rst_res", 32'(res), 32'd0);
        rst_n = 1'b1;
        step();

        send_word(8'b10_00_01_10, 1'b0);
        finish_word("w_7_16", 5'b00111);

        send_word(8'b01_01_01_01, 1'b0);
        finish_word("w_m15_16", 5'b10001);

        send_word(8'b01_10_10_10, 1'b0);
        finish_word("w_m1_16", 5'b11111);

        send_word(8'b11_11_11_11, 1'b0);
`ifdef OTF_ZERO_FLAG_EN
        check("w_zero_flag", 32'(res_zero), 32'd1);
`endif
        finish_word("w_zero", 5'b00000);

        Out_rdy = 1'b0;
        send_word(8'b10_10_10_10, 1'b0);
        x = 2'b10;
        In_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_res", 32'(res), 32'(5'b01111));
            check("stall_vld", 32'(Out_vld), 32'd1);
            check("stall_rdy", 32'(In_rdy), 32'd0);
        end
        Out_rdy = 1'b1;
        step();
        check("stall_release_vld", 32'(Out_vld), 32'd0);
        check("stall_release_rdy", 32'(In_rdy), 32'd1);
        send_word(8'b00_10_00_01, 1'b0);
        finish_word("w_after_stall", 5'b00011);

        send_word(8'b10_00_01_10, 1'b1);
        finish_word("w_toggle", 5'b00111);

        send_digit(2'b10);
        send_digit(2'b10);
        In_vld = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_in_rdy", 32'(In_rdy), 32'd1);
        check("midrst_out_vld", 32'(Out_vld), 32'd0);
        check("midrst_res", 32'(res), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        send_word(8'b01_00_10_00, 1'b0);
        finish_word("w_after_rst", 5'b11010);

        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
